alu_arb_ctrl: RTL and testbench
===============================

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset; clock port clk, reset port rst.
REQ-002 Parameter DEF_PRIO, default 0, meaning requester granted first on a tie after reset (0 or 1).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req0 / req1  in  1  operation request, held with operands until matching done.
REQ-006 func0 / func1  in  3  function code: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110/111 illegal.
REQ-007 a0, b0 / a1, b1  in  16  operands per requester.
REQ-008 done0 / done1  out  1  one-cycle completion pulse to the owning requester.
REQ-009 result_o  out  16  registered result; zero_o, ovf_o, err_o  out  1  registered flags.
REQ-010 busy_o  out  1  high whenever state is not IDLE.
REQ-011 alu_a, alu_b  out  16; alu_ainvert, alu_bnegate, alu_cin  out  1; alu_op  out  3  shared 16-bit ALU drive.
REQ-012 alu_result  in  16; alu_zero, alu_overflow, alu_cout  in  1  combinational ALU response.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, RESP: IDLE->EXEC when any req is high; EXEC->RESP unconditionally; RESP->IDLE unconditionally.
REQ-014 In IDLE with one req high, that requester SHALL win; with both high, the requester not served last SHALL win (round-robin); the first tie after reset goes to DEF_PRIO.
REQ-015 On IDLE->EXEC the winner's func, a, b and owner id SHALL be latched; later changes or deassertion of req SHALL NOT affect the operation.
REQ-016 In EXEC, alu_* SHALL be driven from the latched values: AND {ainv 0, bneg 0, op 000}; OR {0, 0, 001}; ADD {0, 0, 010}; SUB {0, 1, 010}; SLT {0, 1, 011}; NOR {1, 1, 000}; alu_cin = alu_bnegate.
REQ-017 Outside EXEC, and in EXEC for illegal func, all alu_* outputs SHALL be 0.
REQ-018 At the end of EXEC, result_o <= alu_result, zero_o <= alu_zero, and ovf_o <= alu_overflow for ADD/SUB only (else 0), with err_o <= 0.
REQ-019 For illegal func: result_o <= 0, zero_o <= 0, ovf_o <= 0, err_o <= 1.
REQ-020 In RESP, done of the owner SHALL be high for exactly one cycle and the other done low; the round-robin pointer SHALL update to the owner.
REQ-021 Latency: req sampled in IDLE at cycle N -> done at cycle N+2; result/flags valid from N+2 and held until the next EXEC end.
REQ-022 Back-to-back: the earliest next grant is at N+3; a req still high in the cycle after its done SHALL be treated as a new request.
REQ-023 done0 and done1 SHALL never be high together; busy_o SHALL be high in EXEC and RESP.

Reset
REQ-024 rst SHALL force IDLE, round-robin pointer to "last served = !DEF_PRIO", all outputs 0, and latched registers 0.
REQ-025 rst asserted in EXEC or RESP SHALL abort the operation; no done SHALL follow, and alu_* SHALL be 0 from the next cycle.

Verification
REQ-026 req0 ADD a0=0x0003, b0=0x0005 at cycle N -> done0 at N+2, result_o=0x0008, zero_o=0, ovf_o=0, done1=0.
REQ-027 req1 SUB a1=0x7FFF, b1=0xFFFF -> alu_bnegate=1 and alu_cin=1 in EXEC; result_o=0x8000, ovf_o=1; a following SLT 0xFFFF vs 0x0001 -> result_o=0x0001.
REQ-028 After reset with DEF_PRIO=0, req0 and req1 both held -> done0, then done1, then done0 at 3-cycle spacing; no starvation.
REQ-029 func0=111 -> alu_* stay 0 during EXEC; done0 with err_o=1 and result_o=0x0000.
REQ-030 rst pulsed during EXEC of req0 -> no done0; busy_o=0 and all outputs 0 the cycle after rst; a new req0 is then served normally.
REQ-031 req0 dropped and a0 changed during EXEC -> done0 still pulses with the result from the originally latched operands.

Source files
------------

// File: rtl/alu_arb_ctrl_if.sv
// Bundle between two operation requesters, the arbiter, and the shared 16-bit ALU.
// slave = arbiter side, master = requesters plus ALU side.
interface alu_arb_ctrl_if;
   logic        req0, req1;
   logic [2:0]  func0, func1;
   logic [15:0] a0, b0, a1, b1;
   logic        done0, done1;
   logic [15:0] result_o;
   logic        zero_o, ovf_o, err_o, busy_o;
   logic [15:0] alu_a, alu_b;
   logic        alu_ainvert, alu_bnegate, alu_cin;
   logic [2:0]  alu_op;
   logic [15:0] alu_result;
   logic        alu_zero, alu_overflow, alu_cout;

   modport slave (
      input  req0, req1, func0, func1, a0, b0, a1, b1,
      input  alu_result, alu_zero, alu_overflow, alu_cout,
      output done0, done1, result_o, zero_o, ovf_o, err_o, busy_o,
      output alu_a, alu_b, alu_ainvert, alu_bnegate, alu_cin, alu_op
   );

   modport master (
      output req0, req1, func0, func1, a0, b0, a1, b1,
      output alu_result, alu_zero, alu_overflow, alu_cout,
      input  done0, done1, result_o, zero_o, ovf_o, err_o, busy_o,
      input  alu_a, alu_b, alu_ainvert, alu_bnegate, alu_cin, alu_op
   );
endinterface

// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter sharing one combinational 16-bit ALU between two requesters.
// Each grant runs IDLE -> EXEC -> RESP; results and flags are captured at the end of EXEC.
module alu_arb_ctrl #(
   parameter bit DEF_PRIO = 1'b0
) (
   input logic          clk,
   input logic          rst,
   alu_arb_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [2:0]  func;
      logic [15:0] a;
      logic [15:0] b;
   } op_t;

   state_t      state, state_nx;
   op_t         op_q;
   logic        own_q;
   logic        last_q;
   logic        grant;
   logic        any_req;
   logic        legal, addsub;
   logic        ainv, bneg;
   logic [2:0]  opc;
   logic [15:0] result_q;
   logic        zero_q, ovf_q, err_q;
   logic        unused_cout;

   assign any_req     = bus.req0 | bus.req1;
   assign unused_cout = bus.alu_cout;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant = 1'b0;
      if (bus.req0 && bus.req1) grant = ~last_q;
      else if (bus.req1)        grant = 1'b1;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = EXEC;
         EXEC:    state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ainv   = 1'b0;
      bneg   = 1'b0;
      opc    = 3'b000;
      legal  = 1'b1;
      addsub = 1'b0;
      case (op_q.func)
         3'b000: ;
         3'b001: opc = 3'b001;
         3'b010: begin opc = 3'b010; addsub = 1'b1; end
         3'b011: begin opc = 3'b010; bneg = 1'b1; addsub = 1'b1; end
         3'b100: begin opc = 3'b011; bneg = 1'b1; end
         3'b101: begin ainv = 1'b1; bneg = 1'b1; end
         default: legal = 1'b0;
      endcase
   end

   // ALU is only driven while executing a legal operation.
   always_comb begin
      bus.alu_a       = '0;
      bus.alu_b       = '0;
      bus.alu_ainvert = 1'b0;
      bus.alu_bnegate = 1'b0;
      bus.alu_cin     = 1'b0;
      bus.alu_op      = 3'b000;
      if (state == EXEC && legal) begin
         bus.alu_a       = op_q.a;
         bus.alu_b       = op_q.b;
         bus.alu_ainvert = ainv;
         bus.alu_bnegate = bneg;
         bus.alu_cin     = bneg;
         bus.alu_op      = opc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= '0;
         own_q    <= 1'b0;
         last_q   <= ~DEF_PRIO;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && any_req) begin
            own_q <= grant;
            op_q  <= grant ? op_t'{bus.func1, bus.a1, bus.b1}
                           : op_t'{bus.func0, bus.a0, bus.b0};
         end
         if (state == EXEC) begin
            if (legal) begin
               result_q <= bus.alu_result;
               zero_q   <= bus.alu_zero;
               ovf_q    <= addsub & bus.alu_overflow;
               err_q    <= 1'b0;
            end else begin
               result_q <= '0;
               zero_q   <= 1'b0;
               ovf_q    <= 1'b0;
               err_q    <= 1'b1;
            end
         end
         if (state == RESP) last_q <= own_q;
      end
   end

   assign bus.done0    = (state == RESP) && !own_q;
   assign bus.done1    = (state == RESP) &&  own_q;
   assign bus.busy_o   = (state != IDLE);
   assign bus.result_o = result_q;
   assign bus.zero_o   = zero_q;
   assign bus.ovf_o    = ovf_q;
   assign bus.err_o    = err_q;
endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed bench for alu_arb_ctrl: vector table plus reset, abort and fairness sequences.
// A behavioural 16-bit ALU answers the arbiter's drive combinationally.
module tb_alu_arb_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   alu_arb_ctrl_if bus ();
   alu_arb_ctrl #(.DEF_PRIO(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Reference ALU: a/b optionally inverted, adder with carry-in, SLT from sign xor overflow.
   logic [15:0] m_a, m_b, m_r;
   logic [16:0] m_s;
   logic        m_ov;
   always_comb begin
      m_a  = bus.alu_ainvert ? ~bus.alu_a : bus.alu_a;
      m_b  = bus.alu_bnegate ? ~bus.alu_b : bus.alu_b;
      m_s  = {1'b0, m_a} + {1'b0, m_b} + {16'b0, bus.alu_cin};
      m_ov = (m_a[15] == m_b[15]) && (m_s[15] != m_a[15]);
      m_r  = '0;
      case (bus.alu_op)
         3'b000:  m_r = m_a & m_b;
         3'b001:  m_r = m_a | m_b;
         3'b010:  m_r = m_s[15:0];
         3'b011:  m_r = {15'b0, m_s[15] ^ m_ov};
         default: m_r = '0;
      endcase
      bus.alu_result   = m_r;
      bus.alu_zero     = (m_r == 16'h0000);
      bus.alu_overflow = m_ov;
      bus.alu_cout     = m_s[16];
   end

   typedef struct {
      logic        r0, r1;
      logic [2:0]  f0;
      logic [15:0] a0, b0;
      logic [2:0]  f1;
      logic [15:0] a1, b1;
      logic        d0, d1;
      logic [15:0] res;
      logic        z, o, e;
      logic        ainv, bneg;
      logic [2:0]  op;
   } vec_t;

   localparam int NV = 16;
   vec_t vt [NV];

   function automatic vec_t mk(logic r0, logic r1, logic [2:0] f0, logic [15:0] a0, logic [15:0] b0,
                               logic [2:0] f1, logic [15:0] a1, logic [15:0] b1,
                               logic d0, logic d1, logic [15:0] res, logic z, logic o, logic e,
                               logic ainv, logic bneg, logic [2:0] op);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.f0 = f0; v.a0 = a0; v.b0 = b0;
      v.f1 = f1; v.a1 = a1; v.b1 = b1; v.d0 = d0; v.d1 = d1;
      v.res = res; v.z = z; v.o = o; v.e = e;
      v.ainv = ainv; v.bneg = bneg; v.op = op;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.func0 = 3'b000; bus.func1 = 3'b000;
      bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, " busy"},  {31'b0, bus.busy_o}, 32'd0);
      chk({nm, " done"},  {30'b0, bus.done1, bus.done0}, 32'd0);
      chk({nm, " alu"},   {bus.alu_a, 10'b0, bus.alu_ainvert, bus.alu_bnegate, bus.alu_cin, bus.alu_op},
          32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        v;
      logic [15:0] ea, eb;

      // res, z, o, e derived by hand from the operands (two's complement, 16 bit)
      vt[0]  = mk(1,0, 3'b010,16'h0003,16'h0005, 3'b000,16'h0,16'h0,     1,0, 16'h0008,0,0,0, 0,0,3'b010);
      vt[1]  = mk(0,1, 3'b000,16'h0,16'h0,       3'b011,16'h7FFF,16'hFFFF,0,1,16'h8000,0,1,0, 0,1,3'b010);
      vt[2]  = mk(0,1, 3'b000,16'h0,16'h0,       3'b100,16'hFFFF,16'h0001,0,1,16'h0001,0,0,0, 0,1,3'b011);
      vt[3]  = mk(0,1, 3'b000,16'h0,16'h0,       3'b100,16'h8000,16'h0001,0,1,16'h0001,0,0,0, 0,1,3'b011);
      vt[4]  = mk(1,0, 3'b000,16'hF0F0,16'h0FF0, 3'b000,16'h0,16'h0,     1,0, 16'h00F0,0,0,0, 0,0,3'b000);
      vt[5]  = mk(1,0, 3'b001,16'h1200,16'h0034, 3'b000,16'h0,16'h0,     1,0, 16'h1234,0,0,0, 0,0,3'b001);
      vt[6]  = mk(1,0, 3'b101,16'h00FF,16'h0F00, 3'b000,16'h0,16'h0,     1,0, 16'hF000,0,0,0, 1,1,3'b000);
      vt[7]  = mk(1,0, 3'b010,16'hFFFF,16'h0001, 3'b000,16'h0,16'h0,     1,0, 16'h0000,1,0,0, 0,0,3'b010);
      vt[8]  = mk(1,0, 3'b010,16'h7FFF,16'h0001, 3'b000,16'h0,16'h0,     1,0, 16'h8000,0,1,0, 0,0,3'b010);
      vt[9]  = mk(1,0, 3'b111,16'h1234,16'h5678, 3'b000,16'h0,16'h0,     1,0, 16'h0000,0,0,1, 0,0,3'b000);
      vt[10] = mk(0,1, 3'b000,16'h0,16'h0,       3'b110,16'h1234,16'h0001,0,1,16'h0000,0,0,1, 0,0,3'b000);
      vt[11] = mk(1,0, 3'b011,16'h0005,16'h0005, 3'b000,16'h0,16'h0,     1,0, 16'h0000,1,0,0, 0,1,3'b010);
      // ties: last served is requester 0 here, so requester 1 goes first, then 0
      vt[12] = mk(1,1, 3'b000,16'hFFFF,16'h00FF, 3'b001,16'h0F00,16'h00F0,0,1,16'h0FF0,0,0,0, 0,0,3'b001);
      vt[13] = mk(1,1, 3'b000,16'hFFFF,16'h00FF, 3'b001,16'h0F00,16'h00F0,1,0,16'h00FF,0,0,0, 0,0,3'b000);
      vt[14] = mk(1,0, 3'b100,16'h0001,16'hFFFF, 3'b000,16'h0,16'h0,     1,0, 16'h0000,1,0,0, 0,1,3'b011);
      vt[15] = mk(0,1, 3'b001,16'h0,16'h0,       3'b001,16'h0000,16'h0000,0,1,16'h0000,1,0,0, 0,0,3'b001);

      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      chk_quiet("reset");
      chk("reset result", {bus.result_o, 12'b0, bus.zero_o, bus.ovf_o, bus.err_o, 1'b0}, 32'd0);
      rst = 1'b0;
      tick();
      chk_quiet("post-reset idle");

      // Table: grant, then drop requests and scramble operands while executing.
      for (int i = 0; i < NV; i++) begin
         v = vt[i];
         bus.req0 = v.r0; bus.req1 = v.r1;
         bus.func0 = v.f0; bus.a0 = v.a0; bus.b0 = v.b0;
         bus.func1 = v.f1; bus.a1 = v.a1; bus.b1 = v.b1;
         tick();
         ea = v.e ? 16'h0 : (v.d1 ? v.a1 : v.a0);
         eb = v.e ? 16'h0 : (v.d1 ? v.b1 : v.b0);
         bus.req0 = 1'b0; bus.req1 = 1'b0;
         bus.a0 = ~v.a0; bus.b0 = ~v.b0; bus.a1 = ~v.a1; bus.b1 = ~v.b1;
         bus.func0 = ~v.f0; bus.func1 = ~v.f1;
         chk($sformatf("v%0d exec busy", i), {31'b0, bus.busy_o}, 32'd1);
         chk($sformatf("v%0d exec done", i), {30'b0, bus.done1, bus.done0}, 32'd0);
         chk($sformatf("v%0d exec ctl", i),
             {27'b0, bus.alu_ainvert, bus.alu_bnegate, bus.alu_cin, bus.alu_op[1:0]} | {29'b0, bus.alu_op[2], 2'b0},
             {27'b0, v.ainv, v.bneg, v.bneg, v.op[1:0]} | {29'b0, v.op[2], 2'b0});
         chk($sformatf("v%0d exec op", i), {29'b0, bus.alu_op}, {29'b0, v.op});
         chk($sformatf("v%0d exec ab", i), {bus.alu_a, bus.alu_b}, {ea, eb});
         tick();
         chk($sformatf("v%0d resp done", i), {30'b0, bus.done1, bus.done0}, {30'b0, v.d1, v.d0});
         chk($sformatf("v%0d resp result", i), {16'b0, bus.result_o}, {16'b0, v.res});
         chk($sformatf("v%0d resp flags", i), {29'b0, bus.zero_o, bus.ovf_o, bus.err_o}, {29'b0, v.z, v.o, v.e});
         chk($sformatf("v%0d resp busy", i), {31'b0, bus.busy_o}, 32'd1);
         chk($sformatf("v%0d resp alu", i), {bus.alu_a[12:0], bus.alu_op, bus.alu_b}, 32'd0);
         tick();
         chk_quiet($sformatf("v%0d idle", i));
         chk($sformatf("v%0d held", i), {16'b0, bus.result_o}, {16'b0, v.res});
         idle_inputs();
      end

      // Reset during EXEC aborts the operation.
      bus.req0 = 1'b1; bus.func0 = 3'b010; bus.a0 = 16'h0010; bus.b0 = 16'h0020;
      tick();
      chk("abort exec busy", {31'b0, bus.busy_o}, 32'd1);
      rst = 1'b1;
      bus.req0 = 1'b0;
      tick();
      chk_quiet("abort after rst");
      chk("abort outputs", {bus.result_o, 12'b0, bus.zero_o, bus.ovf_o, bus.err_o, 1'b0}, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("abort no done %0d", k), {30'b0, bus.done1, bus.done0}, 32'd0);
      end
      bus.req0 = 1'b1; bus.func0 = 3'b010; bus.a0 = 16'h0002; bus.b0 = 16'h0002;
      tick();
      bus.req0 = 1'b0;
      tick();
      chk("after abort done0", {30'b0, bus.done1, bus.done0}, 32'd1);
      chk("after abort result", {16'b0, bus.result_o}, 32'h0000_0004);
      tick();

      // Fairness from reset: both held, done0 / done1 / done0 three cycles apart.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req0 = 1'b1; bus.func0 = 3'b010; bus.a0 = 16'h0001; bus.b0 = 16'h0001;
      bus.req1 = 1'b1; bus.func1 = 3'b010; bus.a1 = 16'h0002; bus.b1 = 16'h0002;
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk($sformatf("rr cycle %0d done", k), {30'b0, bus.done1, bus.done0},
             {30'b0, (k == 5), (k == 2 || k == 8)});
         if (k == 2 || k == 8) chk($sformatf("rr cycle %0d res0", k), {16'b0, bus.result_o}, 32'd2);
         if (k == 5)           chk("rr cycle 5 res1", {16'b0, bus.result_o}, 32'd4);
      end
      idle_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
